rule_cfg_scheduler: RTL and testbench
=====================================

RULE_CFG_SCHEDULER -- requirements
Module: rule_cfg_scheduler

Interface
REQ-001 SHALL have parameter RD_TIMEOUT, default 64: cycles allowed for read-back before abort (legal range 2..1023).
REQ-002 SHALL have parameter LAST_SEG, default 5: highest legal addr[10:8] segment code.
REQ-003 SHALL have ports i_clk (input, 1): sole clock, rising edge.
REQ-004 SHALL have port i_rst (input, 1): reset, asynchronous, active-high.
REQ-005 SHALL have ports i_req_valid[1:0], o_req_ready[1:0], i_req_wr[1:0] (1=write, 0=read), i_req_addr[2][31:0] and i_req_wdata[2][31:0]: two requester ports (0 = host CPU, 1 = boot loader).
REQ-006 SHALL have ports o_rsp_valid[1:0], i_rsp_ready[1:0], o_rsp_rdata[2][31:0] and o_rsp_err[1:0]: per-requester response.
REQ-007 SHALL have ports o_rule_wren, o_rule_rden (output, 1), o_rule_addr and o_rule_wdata (output, 32): parser/deparser rule bus.
REQ-008 SHALL have ports i_rule_rdata_valid (input, 1) and i_rule_rdata (input, 32): rule read-back.

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE, WAIT_RD and RESP.
REQ-010 IDLE: o_req_ready[g] SHALL be 1 only for granted g; grant is round-robin, with the last-served port losing ties; a single valid port wins immediately.
REQ-011 Handshake SHALL complete on valid&&ready, latching addr/wdata/wr/port, then go to ISSUE.
REQ-012 ISSUE: SHALL drive o_rule_wren (write) or o_rule_rden (read) for exactly one cycle, with addr/wdata stable that cycle; all other cycles hold the bus at 0.
REQ-013 Write SHALL go ISSUE->RESP; o_rsp_valid rises the cycle after ISSUE with o_rsp_rdata=0 and err=0.
REQ-014 Read SHALL go ISSUE->WAIT_RD, then capture i_rule_rdata on i_rule_rdata_valid and go to RESP, with err=0.
REQ-015 An address with addr[10:8] > LAST_SEG SHALL skip ISSUE, issue no bus pulse, and go to RESP with err=1 and rdata=0.
REQ-016 RESP: o_rsp_valid[port] SHALL hold with stable data until i_rsp_ready[port], then return to IDLE; the same edge may not accept a new request (one idle cycle minimum).
REQ-017 i_rule_rdata_valid arriving outside WAIT_RD SHALL be ignored.
REQ-018 Throughput SHALL be at most one rule transaction in flight; write latency is 2 cycles from accept to o_rsp_valid.

Reset
REQ-019 On i_rst, SHALL go to IDLE and clear o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_rdata, o_rule_wren, o_rule_rden, o_rule_addr, o_rule_wdata and the timeout counter; the round-robin pointer resets to favour port 0.
REQ-020 Reset mid-WAIT_RD SHALL abandon the read with no response; later stray rdata_valid is ignored.

Configuration
REQ-021 With RULE_CFG_TIMEOUT_EN defined, WAIT_RD SHALL count cycles; when the count reaches RD_TIMEOUT without rdata_valid, it goes to RESP with err=1 and rdata=32'hDEAD_BEEF.
REQ-022 Without RULE_CFG_TIMEOUT_EN, the counter SHALL be absent and WAIT_RD waits indefinitely.

Structure
REQ-023 The state enum, segment code constants (0..5: rules, type, type offset, key offset, head shift, meta shift) and the DEAD_BEEF constant SHALL live in parser_pkg.
REQ-024 The round-robin grant SHALL be a sub-module, rr_arb2 (2-way, registered last-grant pointer).

Verification
REQ-025 Port 0 write addr=0x0000_0103, data=0x0000_FF08 -> one-cycle wren with those values 1 cycle after accept; rsp_valid[0] 2 cycles after accept, err=0.
REQ-026 Both ports valid at once from reset -> port 0 served first, then port 1; the next simultaneous pair is served port 0 then port 1 again, alternating.
REQ-027 Port 1 read addr=0x0000_0305, rdata_valid 3 cycles after rden with 0x0001_0A04 -> o_rsp_rdata[1]=0x0001_0A04, err=0.
REQ-028 Write with addr[10:8]=7 -> no wren/rden pulse, rsp err=1.
REQ-029 With RULE_CFG_TIMEOUT_EN and RD_TIMEOUT=8, a read with no rdata_valid -> rsp err=1 and rdata=0xDEAD_BEEF 8 cycles after rden; without the macro, no response after 1000 cycles.
REQ-030 i_rst asserted in WAIT_RD, then rdata_valid pulsed -> all outputs 0, no o_rsp_valid, and the next request is served normally.

Source files
------------

// File: rtl/parser_pkg.sv
// parser_pkg: shared types and constants for the rule configuration scheduler.
// Holds the scheduler state encoding, the rule-bus segment codes carried in
// addr[10:8], the timeout read-back pattern and a small segment range helper.
package parser_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } sched_state_e;

  // Segment codes found in addr[10:8] of a rule-bus address.
  localparam logic [2:0] SEG_RULES       = 3'd0;
  localparam logic [2:0] SEG_TYPE        = 3'd1;
  localparam logic [2:0] SEG_TYPE_OFFSET = 3'd2;
  localparam logic [2:0] SEG_KEY_OFFSET  = 3'd3;
  localparam logic [2:0] SEG_HEAD_SHIFT  = 3'd4;
  localparam logic [2:0] SEG_META_SHIFT  = 3'd5;

  // Read data returned when a read-back never arrives.
  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

  // Width of the read-back timeout counter (covers RD_TIMEOUT up to 1023).
  localparam int unsigned RD_CNT_W = 10;

  // True when a segment code lies above the highest legal segment.
  function automatic logic seg_out_of_range(input logic [2:0]  seg,
                                            input int unsigned last_seg);
    return {29'd0, seg} > last_seg;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant with a registered last-served pointer.
// A lone requester is granted at once; on a tie the port served most recently
// yields. The pointer only moves when the owner accepts a grant (i_take).
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic [1:0] o_gnt
);

  logic last_q;  // 1 = port 1 was served last

  // Grant selection: pass a lone request straight through, split ties by pointer.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = last_q ? 2'b01 : 2'b10;
    end
  end

  // Pointer update; reset behaves as if port 1 went last so port 0 wins the first tie.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (i_rst) begin
      last_q <= 1'b1;
    end else if (i_take) begin
      last_q <= o_gnt[1];
    end
  end

endmodule

// File: rtl/rule_cfg_scheduler.sv
// rule_cfg_scheduler: arbitrates two requesters (0 = host CPU, 1 = boot loader)
// onto the single parser/deparser rule bus, one transaction at a time.
// Flow: IDLE (grant/accept) -> ISSUE (one-cycle wren/rden) -> WAIT_RD (reads)
// -> RESP (hold response until the requester takes it) -> IDLE.
// Addresses whose addr[10:8] segment exceeds LAST_SEG bypass the bus and
// answer with err=1.
// Optional feature: define RULE_CFG_TIMEOUT_EN to abort a read-back after
// RD_TIMEOUT cycles with err=1 and rdata=DEAD_BEEF; otherwise WAIT_RD waits
// indefinitely and no counter exists.
module rule_cfg_scheduler
  import parser_pkg::*;
#(
  parameter int unsigned RD_TIMEOUT = 64,
  parameter int unsigned LAST_SEG   = {29'd0, SEG_META_SHIFT}
) (
  input  logic        i_clk,
  input  logic        i_rst,
  // requester side
  input  logic [1:0]  i_req_valid,
  output logic [1:0]  o_req_ready,
  input  logic [1:0]  i_req_wr,
  input  logic [31:0] i_req_addr  [2],
  input  logic [31:0] i_req_wdata [2],
  // response side
  output logic [1:0]  o_rsp_valid,
  input  logic [1:0]  i_rsp_ready,
  output logic [31:0] o_rsp_rdata [2],
  output logic [1:0]  o_rsp_err,
  // rule bus
  output logic        o_rule_wren,
  output logic        o_rule_rden,
  output logic [31:0] o_rule_addr,
  output logic [31:0] o_rule_wdata,
  input  logic        i_rule_rdata_valid,
  input  logic [31:0] i_rule_rdata
);

  // Elaboration-time parameter sanity.
  if (RD_TIMEOUT < 2 || RD_TIMEOUT > 1023) begin : g_bad_rd_timeout
    $error("rule_cfg_scheduler: RD_TIMEOUT must be within 2..1023");
  end
  if (LAST_SEG > 7) begin : g_bad_last_seg
    $error("rule_cfg_scheduler: LAST_SEG must be within 0..7");
  end

  sched_state_e state_q, state_d;

  logic [1:0]  gnt;
  logic        accept;
  logic        sel_port;
  logic [31:0] sel_addr;
  logic        sel_bad_seg;
  logic        rd_timeout;

  // Latched transaction and response registers.
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        wr_q;
  logic        port_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  rr_arb2 u_arb (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_req  (i_req_valid),
    .i_take (accept),
    .o_gnt  (gnt)
  );

  // The granted port is always a valid one, so its index is simply gnt[1].
  assign sel_port    = gnt[1];
  assign sel_addr    = i_req_addr[sel_port];
  assign sel_bad_seg = seg_out_of_range(sel_addr[10:8], LAST_SEG);

`ifdef RULE_CFG_TIMEOUT_EN
  logic [RD_CNT_W-1:0] rd_cnt_q;

  // The rden cycle counts as 1, so expiry lands RD_TIMEOUT cycles after rden.
  assign rd_timeout = (state_q == WAIT_RD) &&
                      (rd_cnt_q == RD_CNT_W'(RD_TIMEOUT - 1));

  // Read-back timeout counter: loaded on ISSUE, advanced while waiting.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      rd_cnt_q <= RD_CNT_W'(1);
    end else if (state_q == WAIT_RD) begin
      rd_cnt_q <= rd_cnt_q + RD_CNT_W'(1);
    end
  end
`else
  assign rd_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and all handshake/bus/response outputs; every output idles at 0.
  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    o_req_ready    = 2'b00;
    o_rule_wren    = 1'b0;
    o_rule_rden    = 1'b0;
    o_rule_addr    = '0;
    o_rule_wdata   = '0;
    o_rsp_valid    = 2'b00;
    o_rsp_err      = 2'b00;
    o_rsp_rdata[0] = '0;
    o_rsp_rdata[1] = '0;
    unique case (state_q)
      IDLE: begin
        o_req_ready = gnt;
        accept      = |gnt;
        if (accept) begin
          state_d = sel_bad_seg ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        o_rule_wren  = wr_q;
        o_rule_rden  = ~wr_q;
        o_rule_addr  = addr_q;
        o_rule_wdata = wdata_q;
        state_d      = wr_q ? RESP : WAIT_RD;
      end
      WAIT_RD: begin
        if (i_rule_rdata_valid || rd_timeout) begin
          state_d = RESP;
        end
      end
      RESP: begin
        o_rsp_valid[port_q] = 1'b1;
        o_rsp_err[port_q]   = rsp_err_q;
        o_rsp_rdata[port_q] = rsp_rdata_q;
        if (i_rsp_ready[port_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Transaction capture on accept, read-back / timeout capture in WAIT_RD.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: these datapath registers are reset too because reset must leave every bus and response output at 0.
    if (i_rst) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      port_q      <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (accept) begin
      addr_q      <= sel_addr;
      wdata_q     <= i_req_wdata[sel_port];
      wr_q        <= i_req_wr[sel_port];
      port_q      <= sel_port;
      rsp_rdata_q <= '0;
      rsp_err_q   <= sel_bad_seg;
    end else if (state_q == WAIT_RD) begin
      if (i_rule_rdata_valid) begin
        rsp_rdata_q <= i_rule_rdata;
        rsp_err_q   <= 1'b0;
      end else if (rd_timeout) begin
        rsp_rdata_q <= DEAD_BEEF;
        rsp_err_q   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rule_cfg_scheduler.sv
// tb_rule_cfg_scheduler: randomized self-checking bench for rule_cfg_scheduler.
// The reference model works per transaction: it knows which port should be
// served next (lone requester, otherwise the port not served last), whether
// the segment is legal, and the cycle on which the bus pulse and response
// must appear. Build with RULE_CFG_TIMEOUT_EN to exercise the read timeout.
module tb_rule_cfg_scheduler;

  localparam int unsigned RD_TO    = 8;
  localparam int unsigned LAST     = 5;
  localparam int          N_ROUNDS = 200;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [1:0]  i_req_valid;
  logic [1:0]  o_req_ready;
  logic [1:0]  i_req_wr;
  logic [31:0] i_req_addr  [2];
  logic [31:0] i_req_wdata [2];
  logic [1:0]  o_rsp_valid;
  logic [1:0]  i_rsp_ready;
  logic [31:0] o_rsp_rdata [2];
  logic [1:0]  o_rsp_err;
  logic        o_rule_wren;
  logic        o_rule_rden;
  logic [31:0] o_rule_addr;
  logic [31:0] o_rule_wdata;
  logic        i_rule_rdata_valid;
  logic [31:0] i_rule_rdata;

  int n_checks = 0;
  int n_errors = 0;

  // Model state and per-round read-back controls.
  int          last_served;
  int          rd_delay;
  logic [31:0] rd_data;
  bit          rd_none;

  always #5 i_clk = ~i_clk;

  rule_cfg_scheduler #(.RD_TIMEOUT(RD_TO), .LAST_SEG(LAST)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_req_valid        (i_req_valid),
    .o_req_ready        (o_req_ready),
    .i_req_wr           (i_req_wr),
    .i_req_addr         (i_req_addr),
    .i_req_wdata        (i_req_wdata),
    .o_rsp_valid        (o_rsp_valid),
    .i_rsp_ready        (i_rsp_ready),
    .o_rsp_rdata        (o_rsp_rdata),
    .o_rsp_err          (o_rsp_err),
    .o_rule_wren        (o_rule_wren),
    .o_rule_rden        (o_rule_rden),
    .o_rule_addr        (o_rule_addr),
    .o_rule_wdata       (o_rule_wdata),
    .i_rule_rdata_valid (i_rule_rdata_valid),
    .i_rule_rdata       (i_rule_rdata)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"}, o_req_ready, 0);
    check({tag, "_rsp_valid"}, o_rsp_valid, 0);
    check({tag, "_rsp_err"}, o_rsp_err, 0);
    check({tag, "_rdata"}, o_rsp_rdata[0] | o_rsp_rdata[1], 0);
    check({tag, "_bus_en"}, {o_rule_wren, o_rule_rden}, 0);
    check({tag, "_bus_data"}, o_rule_addr | o_rule_wdata, 0);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    i_req_valid = '0;
    i_rsp_ready = '0;
    i_rule_rdata_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    last_served = 1;
  endtask

  task automatic rand_req(input int p);
    logic [2:0] seg;
    i_req_wr[p]    = 1'($urandom_range(1));
    i_req_addr[p]  = $urandom;
    seg = ($urandom_range(3) != 0) ? 3'($urandom_range(LAST)) : 3'($urandom_range(7, LAST + 1));
    i_req_addr[p][10:8] = seg;
    i_req_wdata[p] = $urandom;
  endtask

  // Entered at a negedge with the DUT idle; returns at the negedge after the accept edge.
  task automatic accept_req(input int p, output bit ok);
    int w = 0;
    #1;
    check("grant_ready", o_req_ready, 32'(1) << p);
    while (!o_req_ready[p] && w < 20) begin
      @(negedge i_clk);
      #1;
      w++;
    end
    ok = o_req_ready[p];
    if (!ok) begin
      check("grant_timeout", 0, 1);
      return;
    end
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid[p] = 1'b0;
  endtask

  // Follows an accepted transaction through bus pulse, response and release.
  task automatic finish_txn(input int p);
    bit          wr   = i_req_wr[p];
    logic [31:0] a    = i_req_addr[p];
    logic [31:0] wd   = i_req_wdata[p];
    bit          bad  = (a[10:8] > 3'(LAST));
    int          k = 0, rsp_k = -1, pulses = 0, drive_k = -1, exp_k, h;
    logic [31:0] exp_data;
    bit          exp_err;

    if (bad)          begin exp_k = 1;              exp_err = 1'b0 | 1'b1; exp_data = 32'h0; end
    else if (wr)      begin exp_k = 2;              exp_err = 1'b0;        exp_data = 32'h0; end
    else if (rd_none) begin exp_k = 1 + int'(RD_TO); exp_err = 1'b1;      exp_data = 32'hDEAD_BEEF; end
    else              begin exp_k = rd_delay + 2;   exp_err = 1'b0;        exp_data = rd_data; end

    while (rsp_k < 0 && k < 1200) begin
      if (k > 0) @(negedge i_clk);
      k++;
      i_rule_rdata_valid = 1'b0;
      check("busy_ready", o_req_ready, 0);
      if (o_rule_wren || o_rule_rden) begin
        pulses++;
        check("bus_cycle", k, 1);
        check("bus_wren", o_rule_wren, wr);
        check("bus_rden", o_rule_rden, !wr);
        check("bus_addr", o_rule_addr, a);
        if (wr) check("bus_wdata", o_rule_wdata, wd);
        if (!wr && !rd_none) drive_k = k + rd_delay;
      end else begin
        check("bus_quiet", o_rule_addr | o_rule_wdata, 0);
      end
      if (|o_rsp_valid) begin
        rsp_k = k;
      end else if (k == drive_k) begin
        i_rule_rdata_valid = 1'b1;
        i_rule_rdata       = rd_data;
      end else if (k == 1 && $urandom_range(1) == 1) begin
        // Stray read-back while the bus pulse is still in progress.
        i_rule_rdata_valid = 1'b1;
        i_rule_rdata       = $urandom;
      end
    end

    check("pulses", pulses, bad ? 0 : 1);
    check("rsp_cycle", rsp_k, exp_k);
    check("rsp_valid", o_rsp_valid, 32'(1) << p);
    check("rsp_err", o_rsp_err[p], exp_err);
    check("rsp_rdata", o_rsp_rdata[p], exp_data);
    if (rsp_k < 0) return;

    h = $urandom_range(3);
    for (int i = 0; i < h; i++) begin
      i_rsp_ready[p]     = 1'b0;
      i_rsp_ready[1 - p] = 1'($urandom_range(1));
      if ($urandom_range(1) == 1) begin
        i_rule_rdata_valid = 1'b1;
        i_rule_rdata       = $urandom;
      end
      @(negedge i_clk);
      i_rule_rdata_valid = 1'b0;
      check("hold_valid", o_rsp_valid, 32'(1) << p);
      check("hold_err", o_rsp_err[p], exp_err);
      check("hold_rdata", o_rsp_rdata[p], exp_data);
      check("hold_ready", o_req_ready, 0);
      check("hold_bus", {o_rule_wren, o_rule_rden}, 0);
    end
    i_rsp_ready    = '0;
    i_rsp_ready[p] = 1'b1;
    @(negedge i_clk);
    i_rsp_ready = '0;
    check("rsp_release", o_rsp_valid, 0);
  endtask

  // Presents the requests in mask at once and serves them in model order.
  task automatic run_round(input int mask);
    int order [2];
    int n;
    bit ok;
    if (mask == 3) begin
      order[0] = (last_served == 0) ? 1 : 0;
      order[1] = 1 - order[0];
      n = 2;
    end else begin
      order[0] = (mask == 2) ? 1 : 0;
      order[1] = 0;
      n = 1;
    end
    for (int b = 0; b < 2; b++) if (mask[b]) i_req_valid[b] = 1'b1;
    for (int i = 0; i < n; i++) begin
      accept_req(order[i], ok);
      if (!ok) begin
        do_reset();
        return;
      end
      finish_txn(order[i]);
      last_served = order[i];
    end
  endtask

  task automatic set_req(input int p, input bit wr, input logic [31:0] a, input logic [31:0] d);
    i_req_wr[p]    = wr;
    i_req_addr[p]  = a;
    i_req_wdata[p] = d;
  endtask

  initial begin
    #200_000_0;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int seen;
    i_rst = 1'b1;
    i_req_valid = '0;
    i_req_wr = '0;
    i_req_addr[0] = '0;  i_req_addr[1] = '0;
    i_req_wdata[0] = '0; i_req_wdata[1] = '0;
    i_rsp_ready = '0;
    i_rule_rdata_valid = 1'b0;
    i_rule_rdata = '0;
    rd_delay = 1;
    rd_data = '0;
    rd_none = 1'b0;
    do_reset();
    check_quiet("reset");

    // Simultaneous requests from reset: 0 then 1, and again 0 then 1.
    for (int r = 0; r < 2; r++) begin
      set_req(0, 1'b1, 32'h0000_0010, 32'h1111_0000 + r);
      set_req(1, 1'b0, 32'h0000_0120, 32'h0);
      rd_delay = 2;
      rd_data  = 32'hCAFE_0000 + r;
      run_round(3);
      check("tie_last_port1", last_served, 1);
    end

    // Port 0 write of a legal rule.
    set_req(0, 1'b1, 32'h0000_0103, 32'h0000_FF08);
    run_round(1);

    // Port 1 read with read-back three cycles after rden.
    set_req(1, 1'b0, 32'h0000_0305, 32'h0);
    rd_delay = 3;
    rd_data  = 32'h0001_0A04;
    run_round(2);

    // Illegal segment 7: no bus pulse, error response.
    set_req(0, 1'b1, 32'h0000_0700, 32'h1234_5678);
    run_round(1);

    // Randomized rounds.
    for (int r = 0; r < N_ROUNDS; r++) begin
      int mask;
      mask = $urandom_range(3, 1);
      if (mask[0]) rand_req(0);
      if (mask[1]) rand_req(1);
      rd_delay = $urandom_range(5, 1);
      rd_data  = $urandom;
      run_round(mask);
    end

    // Read with no read-back at all.
`ifdef RULE_CFG_TIMEOUT_EN
    set_req(0, 1'b0, 32'h0000_0200, 32'h0);
    rd_none = 1'b1;
    run_round(1);
    rd_none = 1'b0;
`else
    set_req(0, 1'b0, 32'h0000_0200, 32'h0);
    i_req_valid[0] = 1'b1;
    accept_req(0, ok);
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge i_clk);
      if (|o_rsp_valid) seen++;
    end
    check("no_timeout_rsp", seen, 0);
    do_reset();
    check_quiet("post_wait_reset");
`endif

    // Reset while waiting for read-back, then a stray read-back.
    set_req(1, 1'b0, 32'h0000_0104, 32'h0);
    i_req_valid[1] = 1'b1;
    accept_req(1, ok);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    check_quiet("rst_async");
    @(negedge i_clk);
    i_rst = 1'b0;
    last_served = 1;
    i_rule_rdata_valid = 1'b1;
    i_rule_rdata = 32'h5A5A_5A5A;
    @(negedge i_clk);
    i_rule_rdata_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (|o_rsp_valid) seen++;
      check("after_rst_bus", {o_rule_wren, o_rule_rden}, 0);
      @(negedge i_clk);
    end
    check("after_rst_no_rsp", seen, 0);
    check_quiet("after_rst");

    // Service resumes normally.
    set_req(0, 1'b0, 32'h0000_0502, 32'h0);
    rd_delay = 1;
    rd_data  = 32'h0BAD_F00D;
    run_round(1);
    set_req(0, 1'b1, 32'h0000_0401, 32'h7777_8888);
    set_req(1, 1'b1, 32'h0000_0001, 32'h9999_AAAA);
    run_round(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
